// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arbiter FSM state enum, the port count and the packed per-port
// request bundle used to carry one requester's access through the mux.
// REQ_ADDR_W / REQ_DATA_W size the bundle; mem_arbiter defaults its
// ADDR_W / DATA_W parameters to these so the bundle and the ports line up.
package mem_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic                  lock;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } mem_req_t;

  // Bundle one port's loose request signals into a mem_req_t.
  function automatic mem_req_t pack_req(
    input logic                  req,
    input logic                  we,
    input logic                  lock,
    input logic [REQ_ADDR_W-1:0] addr,
    input logic [REQ_DATA_W-1:0] wdata
  );
    mem_req_t r;
    r.req   = req;
    r.we    = we;
    r.lock  = lock;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the two-port memory arbiter.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; a losing request is simply not granted and must be held.
//
// Ports:
//   req      in  NUM_PORTS  request vector (bit i = port i)
//   rr_last  in  1          port granted most recently (MEM_ARB_RR_EN only)
//   state    in  arb_state_t current arbiter state
//   gnt      out NUM_PORTS  one-hot (or zero) grant vector
//
// Build option: MEM_ARB_RR_EN selects round-robin on an IDLE conflict;
// without it port 0 always wins a conflict. This file is the only place
// the option changes behaviour.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic                 rr_last,
`endif
  input  arb_state_t           state,
  output logic [NUM_PORTS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (state)
      // A locked port owns the memory; the other port is never considered.
      LOCK0: gnt[0] = req[0];
      LOCK1: gnt[1] = req[1];
      default: begin
        if (req[0] && req[1]) begin
`ifdef MEM_ARB_RR_EN
          // rr_last names the last winner, so the other port goes now.
          if (rr_last) begin
            gnt[0] = 1'b1;
          end else begin
            gnt[1] = 1'b1;
          end
`else
          gnt[0] = 1'b1;
`endif
        end else begin
          gnt = req;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 1-cycle-latency data-memory port between the core (port 0) and a secondary master (port 1).
// Latency: grant and mem_* are combinational in the request cycle; read data returns one cycle later.
// Backpressure: a losing requester sees gnt low and must hold req/we/addr/wdata until granted.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req/we/lock/addr/wdata{0,1}    per-port access request
//   gnt{0,1}                       access issued to memory this cycle
//   rvalid{0,1}, rdata{0,1}        read return, routed to the owner of the read
//   mem_addr, mem_wdata            memory address / write data (0 when idle)
//   mem_w_enable, mem_r_enable     memory strobes, mutually exclusive
//   mem_rdata                      memory read data, one cycle after mem_r_enable
//
// Build option: MEM_ARB_RR_EN enables round-robin conflict resolution and the
// rr_last register behind it; the default build uses fixed port-0 priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DATA_W = REQ_DATA_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,

  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_w_enable,
  output logic              mem_r_enable,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state_q, state_d;
  logic       rd_pending_q, rd_pending_d;
  logic       rd_owner_q, rd_owner_d;

  mem_req_t             port_req [NUM_PORTS];
  mem_req_t             win;
  logic [NUM_PORTS-1:0] req_vec;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [NUM_PORTS-1:0] gnt;
  logic                 rd_issue;

  assign port_req[0] = pack_req(req0, we0, lock0,
                                REQ_ADDR_W'(addr0), REQ_DATA_W'(wdata0));
  assign port_req[1] = pack_req(req1, we1, lock1,
                                REQ_ADDR_W'(addr1), REQ_DATA_W'(wdata1));

  assign req_vec = {port_req[1].req, port_req[0].req};

`ifdef MEM_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  mem_arb_pick u_pick (
    .req     (req_vec),
    .rr_last (rr_last_q),
    .state   (state_q),
    .gnt     (pick_gnt)
  );
`else
  mem_arb_pick u_pick (
    .req   (req_vec),
    .state (state_q),
    .gnt   (pick_gnt)
  );
`endif

  // Nothing is issued while reset is held, even if requests are up.
  assign gnt  = pick_gnt & {NUM_PORTS{~reset}};
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Selected request; all-zero when nobody is granted so the memory bus
  // rests at zero and win.req doubles as "an access issues this cycle".
  always_comb begin
    win = '0;
    if (gnt[0]) begin
      win = port_req[0];
    end else if (gnt[1]) begin
      win = port_req[1];
    end
  end

  assign rd_issue     = win.req & ~win.we;
  assign mem_r_enable = rd_issue;
  assign mem_w_enable = win.req & win.we;
  assign mem_addr     = ADDR_W'(win.addr);
  assign mem_wdata    = DATA_W'(win.wdata);

  // FSM next state and read-return tracking.
  always_comb begin
    state_d      = state_q;
    rd_pending_d = rd_issue;
    rd_owner_d   = rd_owner_q;

    if (rd_issue) begin
      rd_owner_d = gnt[1];
    end

    case (state_q)
      IDLE: begin
        // Lock is only taken by a port that actually wins this cycle.
        if (win.req && win.lock) begin
          state_d = gnt[1] ? LOCK1 : LOCK0;
        end
      end
      // In a lock state, dropping lock releases ownership whether or not a
      // final access is issued this cycle; holding lock with req low keeps
      // the other port shut out through the gap.
      LOCK0: begin
        if (!port_req[0].lock) begin
          state_d = IDLE;
        end
      end
      LOCK1: begin
        if (!port_req[1].lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  // Tracks the last winner across every grant, lock states included.
  assign rr_last_d = win.req ? gnt[1] : rr_last_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_q    <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  // A read granted just before reset rises must not return: rvalid is
  // gated by reset in the cycle the pending flag would have fired.
  assign rvalid0 = ~reset & rd_pending_q & ~rd_owner_q;
  assign rvalid1 = ~reset & rd_pending_q &  rd_owner_q;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data-memory port (mem_addr / mem_wdata / mem_rdata / mem_r_enable / mem_w_enable) between two requesters: port 0 is the core load/store path, port 1 is a secondary master (program loader / debug). Sits between the core and memory in top. It performs one grant per cycle, routes 1-cycle-latency read data back to the owning port, and supports a lock for uninterrupted multi-access sequences.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; held with stable we/addr/wdata until granted
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  keep ownership after this access
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access issued to memory this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid for that port
- rdata0 / rdata1  out  DATA_W  read data; both driven from mem_rdata
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_w_enable  out  1  memory write strobe
- mem_r_enable  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_r_enable

## Operation
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE: a single requesting port is granted. When both request, arbitration follows the Configuration rule.
- The granted port with lock asserted in its grant cycle moves the FSM to LOCKi. Otherwise the FSM stays in IDLE.
- LOCKi: only port i can be granted; the other port's req is ignored (gnt=0).
  - req_i & lock_i: grant, stay.
  - req_i & !lock_i: grant, go IDLE.
  - !req_i & !lock_i: go IDLE with no grant.
  - !req_i & lock_i: stay, no grant.
- Granted write: mem_w_enable=1, mem_addr/mem_wdata from the winner, no rvalid.
- Granted read: mem_r_enable=1. The arbiter registers rd_pending=1 and rd_owner=i.
- Next cycle: rvalid_i=1 for exactly one cycle. rdata_i = mem_rdata.
- No grant in a cycle: mem_addr=0, mem_wdata=0, both enables 0.
- At most one of gnt0/gnt1 is high in any cycle. Enables are mutually exclusive.

## Timing
- gnt and mem_* are combinational from req/we/addr/wdata and registered state. A request is issued in the same cycle it wins.
- Read latency is 1 cycle: grant in cycle N gives rvalid in cycle N+1. Back-to-back reads give rvalid every cycle, each routed to its own owner.
- Throughput is 1 access/cycle. Switching owners costs no bubble in IDLE.
- Reset values:
  - state = IDLE
  - rd_pending = 0, rd_owner = 0
  - rr_last = 1
  - all rvalid = 0
- While reset=1: gnt0/gnt1=0, mem_r_enable=mem_w_enable=0, mem_addr/mem_wdata=0.
- Reset mid-operation:
  - A read granted in the cycle before reset produces no rvalid.
  - A held lock is dropped. The FSM restarts in IDLE.
- A request deasserted before grant is a requester protocol violation. Behaviour is only required to be glitch-free on mem_*; the bench flags it.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on conflict in IDLE.
  - The port not granted most recently wins.
  - rr_last updates on every grant, including grants in LOCK states.
  - Since rr_last resets to 1, port 0 wins the first conflict.
- Undefined: fixed priority; port 0 (core) always wins conflicts. rr_last is not implemented.

## Structure
- Shared package mem_arb_pkg holds:
  - the arb_state_t enum (IDLE, LOCK0, LOCK1)
  - constant NUM_PORTS = 2
  - a packed mem_req_t struct (req, we, lock, addr, wdata)
- Sub-module mem_arb_pick: combinational winner select from (req vector, rr_last, state). It is the only place affected by MEM_ARB_RR_EN.
- FSM, read-return tracking and output muxing live in mem_arbiter.

## Test plan
- Single read: req1 read addr=0x40, memory holds 0xDEADBEEF at 0x40.
  - Expected: gnt1 same cycle, mem_r_enable=1, mem_addr=0x40.
  - Next cycle: rvalid1=1, rdata1=0xDEADBEEF, rvalid0=0.
- Conflict: req0 write 0x10←0x11 and req1 write 0x20←0x22 held together for 2 cycles.
  - Fixed priority: gnt0 both cycles.
  - MEM_ARB_RR_EN: gnt0 then gnt1, with mem_addr 0x10 then 0x20.
- Lock: port1 issues 3 reads with lock1=1, lock1=0 on the third, while req0 is held.
  - Expected: gnt1 ×3 consecutive, gnt0 low throughout, gnt0 in the 4th cycle.
- Back-to-back reads alternating ports (0x0, 0x4, 0x8) under RR.
  - Expected: rvalid alternates each cycle, each rdata matches its address.
- Reset asserted the cycle after a port0 read grant.
  - Expected: no rvalid0, all outputs 0, state IDLE.
- Lock with idle gap: port0 locked, req0 low for 3 cycles with lock0=1, req1 high.
  - Expected: gnt1 stays 0 until lock0 drops.
